header_stripper: RTL
====================

Name: header_stripper

Overview:
- Downstream counterpart of the AES stream header insertion stage. Consumes an Avalon-ST packet that begins with a fixed HEADER_SIZE-bit header and compares each header beat against expected_header.
- Forwards only the payload beats, with a regenerated sop.
- Drops packets whose header mismatches or that end inside the header, and reports these with pulses and a saturating drop counter.

Parameters:
- DATA_WIDTH, 128: beat width in bits; multiple of 8.
- HEADER_SIZE, 256: header width in bits; integer multiple of DATA_WIDTH, at least DATA_WIDTH. HDR_BEATS = HEADER_SIZE/DATA_WIDTH.
- CNT_WIDTH, 16: width of drop_cnt.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- data_in  avalon_st_if.slave  DATA_WIDTH  input stream (valid, ready, sop, eop, data, empty)
- expected_header  input  HEADER_SIZE  header to match; quasi-static, sampled per beat
- data_out  avalon_st_if.master  DATA_WIDTH  payload stream
- hdr_mismatch  output  1  one-cycle pulse: packet dropped, header mismatch
- hdr_runt  output  1  one-cycle pulse: packet dropped, eop at or before last header beat
- proto_err  output  1  one-cycle pulse: beat without sop accepted in IDLE (discarded)
- drop_cnt  output  CNT_WIDTH  count of dropped packets (mismatch + runt), saturating at all-ones

Behaviour:
- Reset (asynchronous, active-low, rst_n; clock clk):
  - state=IDLE, beat_cntr=0, mismatch_acc=0, first_pl=0, drop_cnt=0.
  - All pulses 0; data_out.valid/sop/eop=0.
- Handshake: a beat transfers when valid & ready on the same clk edge.
- Header beat k (k=0 first) is compared to expected_header[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] (MSB-first).
- IDLE:
  - data_in.ready=1; data_out.valid=0.
  - Accepted beat with sop:
    - HDR_BEATS==1 and eop: pulse hdr_runt, drop_cnt++, stay IDLE.
    - HDR_BEATS==1, no eop: go DATA if beat matches; otherwise go DROP and pulse hdr_mismatch.
    - HDR_BEATS>1 and eop: runt as above.
    - HDR_BEATS>1, no eop: mismatch_acc = (beat != slice 0), beat_cntr=1, go HEADER.
  - Accepted beat without sop: discard, pulse proto_err, stay IDLE.
- HEADER:
  - data_in.ready=1; data_out.valid=0. sop on the input is ignored outside IDLE.
  - Each accepted beat ORs its compare result into mismatch_acc and increments beat_cntr.
  - eop on any header beat: pulse hdr_runt, drop_cnt++, clear beat_cntr, go IDLE. hdr_mismatch is not pulsed; runt has priority.
  - On the last header beat (beat_cntr==HDR_BEATS-1) without eop: combine its compare with mismatch_acc.
    - Clean: go DATA, set first_pl=1.
    - Otherwise: pulse hdr_mismatch, go DROP.
- DATA (zero-latency combinational pass-through):
  - data_out.valid=data_in.valid; data_in.ready=data_out.ready; data_out.data=data_in.data.
  - data_out.sop=first_pl; data_out.eop=data_in.eop; data_out.empty=eop ? data_in.empty : 0.
  - first_pl clears on the first transfer.
  - Transfer with eop: go IDLE, clear beat_cntr and mismatch_acc.
- DROP:
  - data_in.ready=1; data_out.valid=0.
  - Accepted eop: drop_cnt++ and go IDLE.
  - drop_cnt increments exactly once per dropped packet, including runts.
- Saturation: drop_cnt holds at all-ones.
- No back-pressure on the input outside DATA; header and dropped beats never stall.
- Pulses are registered and asserted the cycle after the deciding beat.
- Reset mid-packet returns to IDLE. Remaining beats of the interrupted packet then arrive without sop and are discarded with proto_err.

Optional Feature:
- Macro: HEADER_STRIPPER_CHECK_EN.
- Defined: header compare, hdr_mismatch and the DROP-on-mismatch path exist as described.
- Undefined:
  - No comparator; header beats are stripped blindly and the last header beat always goes to DATA.
  - hdr_mismatch tied 0; expected_header unused.
  - Runt detection and drop_cnt remain.

Test Plan:
- DATA_WIDTH=128, HEADER_SIZE=256, matching 2-beat header + 3 payload beats (eop, empty=4), data_out.ready=1 -> 3 output beats; sop on beat 1, eop+empty=4 on beat 3; payload bit-exact; no pulses; drop_cnt=0.
- Beat 1 of header differs by 1 bit, 4 payload beats -> no data_out.valid for the packet; hdr_mismatch pulses once; drop_cnt=1. The next matching packet then passes normally.
- Header beat 1 carries eop -> hdr_runt pulse, no output, drop_cnt=1; a second runt makes drop_cnt=2.
- data_out.ready toggles 1/0 every cycle during 5-beat payload -> data_in.ready mirrors it; all 5 beats delivered in order; sop only on first.
- Beat without sop while IDLE -> discarded, proto_err pulses; following valid packet is forwarded intact.
- Assert rst_n=0 during DATA beat 2 of 4, then release -> outputs 0 immediately; the remaining 2 beats raise proto_err each and are discarded; drop_cnt=0; next packet OK. Optional-feature-off run of scenario 2 -> all 4 payload beats are forwarded.

Source files
------------

// File: rtl/header_stripper.sv
// header_stripper: removes a fixed HEADER_SIZE-bit header from each Avalon-ST
// packet, checks it against expected_header and forwards only the payload
// with a regenerated sop. Mismatching and runt packets are dropped and
// reported with one-cycle pulses plus a saturating drop counter.
//
// Optional feature macro: HEADER_STRIPPER_CHECK_EN
//   defined   : header beats are compared; mismatching packets are dropped
//   undefined : header beats are stripped blindly, hdr_mismatch stays 0,
//               expected_header is unused; runt detection and drop_cnt remain
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   data_in_*               input stream  (valid, ready, sop, eop, data, empty)
//   expected_header         header to match, MSB-first, beat 0 in the top bits
//   data_out_*              payload stream (valid, ready, sop, eop, data, empty)
//   hdr_mismatch            pulse: packet dropped, header mismatch
//   hdr_runt                pulse: packet dropped, eop inside the header
//   proto_err               pulse: beat without sop discarded in IDLE
//   drop_cnt                dropped packet count, saturating
module header_stripper #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned HEADER_SIZE = 256,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned EMPTY_W    = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  input  logic                   data_in_sop,
  input  logic                   data_in_eop,
  input  logic [DATA_WIDTH-1:0]  data_in_data,
  input  logic [EMPTY_W-1:0]     data_in_empty,
  input  logic [HEADER_SIZE-1:0] expected_header,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   data_out_sop,
  output logic                   data_out_eop,
  output logic [DATA_WIDTH-1:0]  data_out_data,
  output logic [EMPTY_W-1:0]     data_out_empty,
  output logic                   hdr_mismatch,
  output logic                   hdr_runt,
  output logic                   proto_err,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);

  localparam int unsigned HDR_BEATS = HEADER_SIZE / DATA_WIDTH;
  localparam int unsigned CNTR_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam logic [CNTR_W-1:0] LAST_BEAT = CNTR_W'(HDR_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DROP} state_t;

  state_t              state;
  logic [CNTR_W-1:0]   beat_cntr;
  logic                mismatch_acc;
  logic                first_pl;
  logic                xfer;
  logic                beat_mm;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Outside DATA the input is never back-pressured; in DATA it is a wire-through.
  always_comb begin
    data_in_ready  = (state == DATA) ? data_out_ready : 1'b1;
    data_out_valid = (state == DATA) & data_in_valid;
    data_out_sop   = (state == DATA) & first_pl;
    data_out_eop   = (state == DATA) & data_in_eop;
    data_out_data  = data_in_data;
    data_out_empty = ((state == DATA) && data_in_eop) ? data_in_empty : '0;
  end

  assign xfer = data_in_valid & data_in_ready;

`ifdef HEADER_STRIPPER_CHECK_EN
  logic [CNTR_W-1:0]     sel_k;
  logic [DATA_WIDTH-1:0] exp_beat;

  // In IDLE the incoming beat is always header beat 0.
  assign sel_k = (state == HEADER) ? beat_cntr : '0;

  always_comb begin
    exp_beat = '0;
    for (int k = 0; k < HDR_BEATS; k++) begin
      if (CNTR_W'(k) == sel_k)
        exp_beat = expected_header[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH];
    end
  end

  assign beat_mm = (data_in_data != exp_beat);
`else
  logic unused_hdr;
  assign unused_hdr = ^expected_header;
  assign beat_mm    = 1'b0;
`endif

  // Packet FSM, registered pulses and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cntr    <= '0;
      mismatch_acc <= 1'b0;
      first_pl     <= 1'b0;
      drop_cnt     <= '0;
      hdr_mismatch <= 1'b0;
      hdr_runt     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      hdr_mismatch <= 1'b0;
      hdr_runt     <= 1'b0;
      proto_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (!data_in_sop) begin
              proto_err <= 1'b1;
            end else if (data_in_eop) begin
              hdr_runt <= 1'b1;
              drop_cnt <= sat_inc(drop_cnt);
            end else if (HDR_BEATS == 1) begin
              if (beat_mm) begin
                hdr_mismatch <= 1'b1;
                state        <= DROP;
              end else begin
                first_pl <= 1'b1;
                state    <= DATA;
              end
            end else begin
              mismatch_acc <= beat_mm;
              beat_cntr    <= CNTR_W'(1);
              state        <= HEADER;
            end
          end
        end
        HEADER: begin
          if (xfer) begin
            if (data_in_eop) begin
              // Runt wins over a pending mismatch.
              hdr_runt     <= 1'b1;
              drop_cnt     <= sat_inc(drop_cnt);
              beat_cntr    <= '0;
              mismatch_acc <= 1'b0;
              state        <= IDLE;
            end else if (beat_cntr == LAST_BEAT) begin
              beat_cntr    <= '0;
              mismatch_acc <= 1'b0;
              if (mismatch_acc | beat_mm) begin
                hdr_mismatch <= 1'b1;
                state        <= DROP;
              end else begin
                first_pl <= 1'b1;
                state    <= DATA;
              end
            end else begin
              mismatch_acc <= mismatch_acc | beat_mm;
              beat_cntr    <= beat_cntr + CNTR_W'(1);
            end
          end
        end
        DATA: begin
          if (xfer) begin
            first_pl <= 1'b0;
            if (data_in_eop) begin
              beat_cntr    <= '0;
              mismatch_acc <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        DROP: begin
          if (xfer && data_in_eop) begin
            drop_cnt <= sat_inc(drop_cnt);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
